// File: rtl/address_unit.sv
// Program counter and memory address register for the CPU datapath.
// Branch targets are staged low byte first and committed atomically on the high byte.
module address_unit #(
   parameter logic [15:0] ORIGIN = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  i_bus_in,
   input  logic        i_load_origin,
   input  logic        i_pc_enable,
   input  logic        i_load_pc_low_byte,
   input  logic        i_load_pc_high_byte,
   input  logic        i_load_mar_pc,
   input  logic        i_load_mar_addr_low,
   input  logic        i_load_mar_addr_high,
   output logic [15:0] o_mem_addr,
   output logic [15:0] o_pc_out,
   output logic        o_pc_low_pending,
   output logic        o_pc_wrap
);

   logic [15:0] r_pc;
   logic [15:0] r_mar;
   logic [7:0]  r_pc_low_stage;
   logic        r_pc_low_pending;
   logic        r_pc_wrap;

   logic [15:0] w_pc_next;
   logic [15:0] w_mar_next;
   logic        w_pending_next;
   logic        w_wrap_next;
   logic [7:0]  w_commit_low;

   // A same-cycle stage+commit takes the low byte straight from the bus.
   assign w_commit_low = i_load_pc_low_byte ? i_bus_in : r_pc_low_stage;

   always_comb begin
      w_pc_next      = r_pc;
      w_pending_next = r_pc_low_pending;
      w_wrap_next    = 1'b0;
      if (i_load_pc_low_byte)
         w_pending_next = 1'b1;
      if (i_load_origin) begin
         w_pc_next      = ORIGIN;
         w_pending_next = 1'b0;
      end else if (i_load_pc_high_byte) begin
         w_pc_next      = {i_bus_in, w_commit_low};
         w_pending_next = 1'b0;
      end else if (i_pc_enable) begin
         w_pc_next   = r_pc + 16'd1;
         w_wrap_next = (r_pc == 16'hFFFF);
      end
   end

   // MAR snapshots the PC as it was before this cycle's update.
   always_comb begin
      w_mar_next = r_mar;
      if (i_load_mar_pc) begin
         w_mar_next = r_pc;
      end else begin
         if (i_load_mar_addr_low)
            w_mar_next[7:0] = i_bus_in;
         if (i_load_mar_addr_high)
            w_mar_next[15:8] = i_bus_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc             <= 16'h0000;
         r_mar            <= 16'h0000;
         r_pc_low_stage   <= 8'h00;
         r_pc_low_pending <= 1'b0;
         r_pc_wrap        <= 1'b0;
      end else begin
         r_pc             <= w_pc_next;
         r_mar            <= w_mar_next;
         r_pc_low_pending <= w_pending_next;
         r_pc_wrap        <= w_wrap_next;
         if (i_load_pc_low_byte)
            r_pc_low_stage <= i_bus_in;
      end
   end

   assign o_mem_addr       = r_mar;
   assign o_pc_out         = r_pc;
   assign o_pc_low_pending = r_pc_low_pending;
   assign o_pc_wrap        = r_pc_wrap;

endmodule
